// File: rtl/swi_pkg.sv
// rtl/swi_pkg.sv - shared sizing constants for the switch conditioning path
package swi_pkg;

    localparam int NBITS_TOP        = 8;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int GLITCH_W_DEFAULT = 8;

    // Debounce counter width; a single-cycle filter still needs one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch bit: 2-flop synchronizer, debounce filter, edge pulses
module debounce_bit
    import swi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_2,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic abort
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ;
    logic             accept;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        differ   = (sync2_q != stable_q);
        accept   = differ && (cnt_q == CNT_LAST);
        stable_d = accept ? sync2_q : stable_q;
        if (!differ || accept) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        rise_d = accept && sync2_q;
        fall_d = accept && !sync2_q;
    end

    // A pending transition that falls back to the stable level is a rejected glitch.
    assign abort  = !differ && (cnt_q != '0);
    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/swi_conditioner.sv
// rtl/swi_conditioner.sv - switch bank conditioner: per-bit debounce plus saturating glitch counter
module swi_conditioner
    import swi_pkg::*;
#(
    parameter int NBITS           = NBITS_TOP,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int GLITCH_W        = GLITCH_W_DEFAULT
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic [NBITS-1:0]    swi_raw,
    output logic [NBITS-1:0]    swi_stable,
    output logic [NBITS-1:0]    swi_rise,
    output logic [NBITS-1:0]    swi_fall,
    output logic [GLITCH_W-1:0] glitch_count
);

    logic [NBITS-1:0]    abort_vec;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_2  (clk_2),
            .reset  (reset),
            .raw    (swi_raw[i]),
            .stable (swi_stable[i]),
            .rise   (swi_rise[i]),
            .fall   (swi_fall[i]),
            .abort  (abort_vec[i])
        );
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    // Counts cycles with any abort, not aborted bits; sticks at all-ones.
    always_comb begin
        glitch_d = glitch_q;
        if ((|abort_vec) && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    assign glitch_count = glitch_q;

endmodule
